// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix scan driver: slot-state encoding and
// default geometry/timing constants used as parameter defaults.
package led_matrix_pkg;

    // Phase within one column slot: outputs dark, or column strobed with row data
    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_t;

    localparam int DEF_ROWS         = 8;
    localparam int DEF_COLS         = 4;
    localparam int DEF_DWELL_W      = 10;
    localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/led_scan_timer.sv
// Scan timebase: per-column slot counter, current column index, slot phase
// (BLANK/DRIVE) and the frame-boundary strike used for buffer swap and
// frame_start. All values describe the slot position of the current clock.
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int COLS         = DEF_COLS,
    parameter int DWELL_W      = DEF_DWELL_W,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int COL_W       = $clog2(COLS)
)(
    input  logic             clk12MHz,
    input  logic             rst_n,
    output logic [COL_W-1:0] col_idx,
    output slot_state_t      state,
    output logic             swap
);

    localparam logic [DWELL_W-1:0] CNT_LAST  = '1;
    localparam logic [DWELL_W-1:0] BLANK_LIM = DWELL_W'(BLANK_CYCLES);
    localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(COLS - 1);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [COL_W-1:0]   col_nxt;
    slot_state_t        state_nxt;

    // Next slot position; the phase is derived from the next count so the
    // state register always matches the count it sits beside
    always_comb begin
        cnt_nxt   = cnt + DWELL_W'(1);
        col_nxt   = col_idx;
        state_nxt = SLOT_DRIVE;
        if (cnt == CNT_LAST) begin
            col_nxt = (col_idx == COL_LAST) ? '0 : col_idx + COL_W'(1);
        end
        if (cnt_nxt < BLANK_LIM) begin
            state_nxt = SLOT_BLANK;
        end
    end

    // Timebase registers; reset restarts the scan at column 0, slot start
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            col_idx <= '0;
            state   <= SLOT_BLANK;
        end else begin
            cnt     <= cnt_nxt;
            col_idx <= col_nxt;
            state   <= state_nxt;
        end
    end

    // First clock of the column-0 slot: frame boundary
    assign swap = (cnt == '0) && (col_idx == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexed LED matrix driver: double-buffered frame store, anti-ghost
// blanking at each column change, active-low registered row/column pins.
// Optional global dimming is enabled by defining LED_MATRIX_DIMMING_EN, which
// adds the 4-bit brightness input and a per-slot PWM gate on the row lines.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DWELL_W      = DEF_DWELL_W,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
)(
    input  logic                 clk12MHz,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] frame_data,
    input  logic                 frame_load,
`ifdef LED_MATRIX_DIMMING_EN
    input  logic [3:0]           brightness,
`endif
    output logic                 frame_pend,
    output logic                 frame_start,
    output logic [ROWS-1:0]      led_row,
    output logic [COLS-1:0]      led_col
);

    localparam int COL_W = $clog2(COLS);

    logic [COLS-1:0][ROWS-1:0] active_buf;
    logic [COLS-1:0][ROWS-1:0] shadow_buf;
    logic [COL_W-1:0]          col_idx;
    slot_state_t               state;
    logic                      swap;
    logic                      row_en;
    logic [ROWS-1:0]           row_nxt;
    logic [COLS-1:0]           col_nxt;

    led_scan_timer #(
        .COLS         (COLS),
        .DWELL_W      (DWELL_W),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk12MHz (clk12MHz),
        .rst_n    (rst_n),
        .col_idx  (col_idx),
        .state    (state),
        .swap     (swap)
    );

    // Frame handshake: loads land in shadow; shadow moves to active only at the
    // frame boundary, and a load on that very clock goes straight to both
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            active_buf <= '0;
            shadow_buf <= '0;
            frame_pend <= 1'b0;
        end else if (swap && frame_load) begin
            active_buf <= frame_data;
            shadow_buf <= frame_data;
            frame_pend <= 1'b0;
        end else if (frame_load) begin
            shadow_buf <= frame_data;
            frame_pend <= 1'b1;
        end else if (swap && frame_pend) begin
            active_buf <= shadow_buf;
            frame_pend <= 1'b0;
        end
    end

`ifdef LED_MATRIX_DIMMING_EN
    logic [3:0] pwm_cnt;

    // PWM phase inside the drive window; held at zero through blanking so every
    // slot starts its duty pattern from the beginning
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (state == SLOT_BLANK) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign row_en = (pwm_cnt <= brightness);
`else
    assign row_en = 1'b1;
`endif

    // Pin values for the current slot position: dark while blanking, otherwise
    // one column low and its rows inverted (rows may be gated off by dimming)
    always_comb begin
        row_nxt = '1;
        col_nxt = '1;
        if (state == SLOT_DRIVE) begin
            col_nxt = ~(COLS'(1) << col_idx);
            if (row_en) begin
                row_nxt = ~active_buf[col_idx];
            end
        end
    end

    // Registered pins; reset forces everything dark immediately
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            led_row     <= '1;
            led_col     <= '1;
            frame_start <= 1'b0;
        end else begin
            led_row     <= row_nxt;
            led_col     <= col_nxt;
            frame_start <= swap;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan (default geometry 8x4, 1024-clock
// slots, 16 blank clocks). Builds with or without LED_MATRIX_DIMMING_EN.
`timescale 1ns/1ps
module tb_led_matrix_scan;

    localparam int ROWS  = 8;
    localparam int COLS  = 4;
    localparam int DWELL = 10;
    localparam int BLANK = 16;
    localparam int SLOT  = 1 << DWELL;
    localparam int FRAME = SLOT * COLS;

    logic        clk12MHz = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] frame_data = '0;
    logic        frame_load = 1'b0;
`ifdef LED_MATRIX_DIMMING_EN
    logic [3:0]  brightness = 4'd15;
`endif
    logic        frame_pend;
    logic        frame_start;
    logic [7:0]  led_row;
    logic [3:0]  led_col;

    always #5 clk12MHz = ~clk12MHz;

    led_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .DWELL_W(DWELL), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk12MHz    (clk12MHz),
        .rst_n       (rst_n),
        .frame_data  (frame_data),
        .frame_load  (frame_load),
`ifdef LED_MATRIX_DIMMING_EN
        .brightness  (brightness),
`endif
        .frame_pend  (frame_pend),
        .frame_start (frame_start),
        .led_row     (led_row),
        .led_col     (led_col)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  row0;
        logic [7:0]  row3;
    } vec_t;

    vec_t        tbl [4];
    int          checks   = 0;
    int          failures = 0;
    int unsigned pos;          // scan position the next clock edge acts on
    logic [31:0] m_active;
    logic [31:0] m_shadow;
    logic        m_pend;
    int          ones_run;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] col_bits(input logic [31:0] f, input int unsigned c);
        return f[c*8 +: 8];
    endfunction

    task automatic model_reset();
        pos      = 0;
        m_active = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        ones_run = 0;
    endtask

    // One clock: predict the pins from the scan position, update the frame
    // model with the inputs seen at this edge, then compare after the edge
    task automatic tick();
        int unsigned p, off, c;
        logic [7:0]  er;
        logic [3:0]  ec;
        logic        efs;
        logic        lit;
        p   = pos;
        off = p % SLOT;
        c   = (p / SLOT) % COLS;
        efs = (p % FRAME == 0);
        er  = 8'hFF;
        ec  = 4'hF;
        if (off >= BLANK) begin
            ec[c] = 1'b0;
            lit   = 1'b1;
`ifdef LED_MATRIX_DIMMING_EN
            lit   = (((off - BLANK) % 16) <= brightness);
`endif
            if (lit) er = ~col_bits(m_active, c);
        end
        if (efs) begin
            if (frame_load) begin
                m_active = frame_data;
                m_shadow = frame_data;
                m_pend   = 1'b0;
            end else if (m_pend) begin
                m_active = m_shadow;
                m_pend   = 1'b0;
            end
        end else if (frame_load) begin
            m_shadow = frame_data;
            m_pend   = 1'b1;
        end
        @(posedge clk12MHz);
        #1;
        check($sformatf("scan@%0d col_row_fs_pend", p),
              {led_col, led_row, frame_start, frame_pend}, {ec, er, efs, m_pend});
        check("col_onehot", ($countones(~led_col) <= 1), 1);
        if (led_col == 4'hF) begin
            ones_run++;
        end else begin
            if (ones_run != 0) check($sformatf("blank_len@%0d", p), ones_run, BLANK);
            ones_run = 0;
        end
        pos++;
    endtask

    task automatic advance_to(input int unsigned target);
        while (pos <= target) tick();
    endtask

    task automatic do_load(input logic [31:0] d);
        frame_data = d;
        frame_load = 1'b1;
        tick();
        frame_load = 1'b0;
        frame_data = $urandom;
    endtask

    function automatic int unsigned next_frame();
        return ((pos + FRAME - 1) / FRAME) * FRAME;
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned fb, ld, nf, f, g, k;
        int          lows;

        tbl[0] = '{32'h8000_0001, 8'hFE, 8'h7F};
        tbl[1] = '{32'h0000_00FF, 8'h00, 8'hFF};
        tbl[2] = '{32'hA500_0000, 8'hFF, 8'h5A};
        tbl[3] = '{32'h1234_5678, 8'h87, 8'hED};

        // Reset state
        #12;
        check("rst_row",  led_row, 8'hFF);
        check("rst_col",  led_col, 4'hF);
        check("rst_pend", frame_pend, 0);
        check("rst_fs",   frame_start, 0);
        @(negedge clk12MHz);
        rst_n = 1'b1;
        model_reset();

        // First frame after release: blank 16 clocks, then column 0 dark rows
        tick();
        check("init_fs", frame_start, 1);
        check("init_col_blank", led_col, 4'hF);
        advance_to(15);
        check("init_col_blank_end", led_col, 4'hF);
        tick();
        check("init_col_drive", led_col, 4'hE);
        check("init_row", led_row, 8'hFF);
        check("init_fs_once", frame_start, 0);

        // Table-driven frame loads, each shown from the following frame
        for (int i = 0; i < 4; i++) begin
            fb = (pos / FRAME) * FRAME;
            ld = (pos % FRAME < 3500) ? fb + 3500 : fb + FRAME + 3500;
            nf = (ld / FRAME + 1) * FRAME;
            advance_to(ld - 1);
            do_load(tbl[i].data);
            check($sformatf("tbl%0d_pend_set", i), frame_pend, 1);
            advance_to(nf);
            check($sformatf("tbl%0d_fs", i), frame_start, 1);
            check($sformatf("tbl%0d_pend_clr", i), frame_pend, 0);
            advance_to(nf + 100);
            check($sformatf("tbl%0d_col0", i), led_col, 4'hE);
            check($sformatf("tbl%0d_row0", i), led_row, tbl[i].row0);
            advance_to(nf + 3*SLOT + 100);
            check($sformatf("tbl%0d_col3", i), led_col, 4'h7);
            check($sformatf("tbl%0d_row3", i), led_row, tbl[i].row3);
        end

        // Two loads in one frame: last wins, nothing changes before the wrap
        f = next_frame();
        advance_to(f + 1500);
        do_load(32'h0000_0001);
        advance_to(f + 2600);
        do_load(32'h0000_0002);
        check("dbl_pend", frame_pend, 1);
        advance_to(f + 3200);
        check("dbl_no_tear", led_row, 8'hED);
        advance_to(f + FRAME + 100);
        check("dbl_row0", led_row, 8'hFD);
        check("dbl_pend_clr", frame_pend, 0);
        advance_to(f + FRAME + SLOT + 100);
        check("dbl_row1", led_row, 8'hFF);

        // Load on the swap clock goes straight to the display
        g = next_frame();
        advance_to(g - 1);
        do_load(32'hC3C3_3C3C);
        check("swapld_pend", frame_pend, 0);
        check("swapld_fs", frame_start, 1);
        advance_to(g + 100);
        check("swapld_row0", led_row, 8'hC3);

        // Randomised loads (and brightness when dimming) against the model
        for (int n = 0; n < 2*FRAME; n++) begin
`ifdef LED_MATRIX_DIMMING_EN
            brightness = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 299) == 0) do_load($urandom);
            else tick();
        end

`ifdef LED_MATRIX_DIMMING_EN
        // Duty check with every LED on
        brightness = 4'd3;
        do_load(32'hFFFF_FFFF);
        g = next_frame();
        advance_to(g + BLANK - 1);
        lows = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (led_row == 8'h00) lows++;
        end
        check("dim_b3_lows", lows, 16);
        brightness = 4'd15;
        lows = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (led_row == 8'h00) lows++;
        end
        check("dim_b15_lows", lows, 64);
`endif

        // Reset in the middle of column 2 drive with a frame pending
        k = next_frame();
        advance_to(k + 2*SLOT + 300);
        do_load(32'h5A5A_5A5A);
        check("midrst_pend_before", frame_pend, 1);
        advance_to(k + 2*SLOT + 500);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_row", led_row, 8'hFF);
        check("midrst_col", led_col, 4'hF);
        check("midrst_pend", frame_pend, 0);
        @(negedge clk12MHz);
        @(negedge clk12MHz);
        rst_n = 1'b1;
        model_reset();
        tick();
        check("midrst_fs", frame_start, 1);
        advance_to(20);
        check("midrst_col0", led_col, 4'hE);
        check("midrst_row0", led_row, 8'hFF);
        check("midrst_pend_after", frame_pend, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
